// File: rtl/sad_accum_pipe.sv
// Pipelined sum-of-absolute-differences engine: per-beat |cur-ref| pixel differences,
// carry-save reduction to a row sum, and accumulation of row sums into one SAD per block.
module sad_accum_pipe #(
  parameter int N_PIX     = 8,
  parameter int PIX_W     = 8,
  parameter int BLK_BEATS = 8,
  localparam int RW = PIX_W + $clog2(N_PIX),
  localparam int AW = RW + $clog2(BLK_BEATS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N_PIX*PIX_W-1:0] i_cur,
  input  logic [N_PIX*PIX_W-1:0] i_ref,
  output logic                   o_sad_valid,
  input  logic                   i_sad_ready,
  output logic [AW-1:0]          o_sad,
  output logic                   o_busy
);

  localparam int CW   = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
  localparam int HALF = N_PIX / 2;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [RW-1:0] maj(input logic [RW-1:0] a,
                                        input logic [RW-1:0] b,
                                        input logic [RW-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic          adv;
  logic          accept;
  logic          beat_last;
  logic [CW-1:0] cnt;

  logic             s1_valid;
  logic             s1_last;
  logic [PIX_W-1:0] s1_diff [N_PIX];

  logic          s2_valid;
  logic          s2_last;
  logic [RW-1:0] s2_sum;
  logic [RW-1:0] s2_carry;

  logic [RW-1:0] tree_s [N_PIX-1];
  logic [RW-1:0] tree_c [N_PIX-1];

  logic [RW-1:0] row;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;

  assign adv       = !o_sad_valid | i_sad_ready;
  assign o_ready   = adv & !i_clear;
  assign accept    = i_valid & o_ready;
  assign beat_last = (cnt == CW'(BLK_BEATS - 1));
  assign o_busy    = (cnt != '0) | s1_valid | s2_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= beat_last ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int k = 0; k < N_PIX; k++) s1_diff[k] <= '0;
    end else if (i_clear) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      s1_last  <= accept & beat_last;
      for (int k = 0; k < N_PIX; k++)
        s1_diff[k] <= abs_diff(i_cur[k*PIX_W +: PIX_W], i_ref[k*PIX_W +: PIX_W]);
    end
  end

  // Heap-ordered tree: node j has children 2j+1 and 2j+2; the bottom row pairs raw
  // differences as (sum, carry), every level above it is a 4:2 built from two 3:2s.
  // Carries out of the MSB are dropped: the true total always fits in RW bits.
  for (genvar j = 0; j < N_PIX - 1; j++) begin : g_node
    if (j >= HALF - 1) begin : g_leaf
      assign tree_s[j] = RW'(s1_diff[2*(j-HALF+1)]);
      assign tree_c[j] = RW'(s1_diff[2*(j-HALF+1)+1]);
    end else begin : g_cmp42
      logic [RW-1:0] s_a;
      logic [RW-1:0] m_a;
      logic [RW-1:0] c_a;
      logic [RW-1:0] m_b;
      assign s_a       = tree_s[2*j+1] ^ tree_c[2*j+1] ^ tree_s[2*j+2];
      assign m_a       = maj(tree_s[2*j+1], tree_c[2*j+1], tree_s[2*j+2]);
      assign c_a       = m_a << 1;
      assign m_b       = maj(s_a, c_a, tree_c[2*j+2]);
      assign tree_s[j] = s_a ^ c_a ^ tree_c[2*j+2];
      assign tree_c[j] = m_b << 1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
      s2_carry <= '0;
    end else if (i_clear) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_sum   <= tree_s[0];
      s2_carry <= tree_c[0];
    end
  end

  assign row      = s2_sum + s2_carry;
  assign acc_next = acc + AW'(row);

  // A clear aborts whatever is in flight, including a completing row; a result
  // already presented downstream is untouched and still handshakes normally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc         <= '0;
      o_sad       <= '0;
      o_sad_valid <= 1'b0;
    end else begin
      if (i_clear) begin
        acc <= '0;
      end else if (adv && s2_valid) begin
        acc <= s2_last ? '0 : acc_next;
      end

      if (!i_clear && adv && s2_valid && s2_last) begin
        o_sad       <= acc_next;
        o_sad_valid <= 1'b1;
      end else if (i_sad_ready) begin
        o_sad_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sad_accum_pipe.sv
// Scoreboard bench for sad_accum_pipe: default configuration with directed and random
// traffic, plus a 16x10-bit, 4-beat instance under random traffic.
module tb_sad_accum_pipe;

  localparam int NA = 8,  WA = 8,  BA = 8, AWA = 14;
  localparam int NB = 16, WB = 10, BB = 4, AWB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic              a_clear = 1'b0, a_valid = 1'b0, a_sad_ready = 1'b1;
  logic              a_ready, a_sad_valid, a_busy;
  logic [NA*WA-1:0]  a_cur = '0, a_ref = '0;
  logic [AWA-1:0]    a_sad;

  logic              b_clear = 1'b0, b_valid = 1'b0, b_sad_ready = 1'b1;
  logic              b_ready, b_sad_valid, b_busy;
  logic [NB*WB-1:0]  b_cur = '0, b_ref = '0;
  logic [AWB-1:0]    b_sad;

  sad_accum_pipe #(.N_PIX(NA), .PIX_W(WA), .BLK_BEATS(BA)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(a_clear), .i_valid(a_valid),
    .o_ready(a_ready), .i_cur(a_cur), .i_ref(a_ref), .o_sad_valid(a_sad_valid),
    .i_sad_ready(a_sad_ready), .o_sad(a_sad), .o_busy(a_busy)
  );

  sad_accum_pipe #(.N_PIX(NB), .PIX_W(WB), .BLK_BEATS(BB)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(b_clear), .i_valid(b_valid),
    .o_ready(b_ready), .i_cur(b_cur), .i_ref(b_ref), .o_sad_valid(b_sad_valid),
    .i_sad_ready(b_sad_ready), .o_sad(b_sad), .o_busy(b_busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Reference model: a block's SAD is the plain sum of |cur-ref| over all its pixels.
  longint qa[$], qb[$];
  longint a_part = 0, b_part = 0;
  int     a_n = 0, b_n = 0;
  bit     a_model = 1'b0;

  function automatic longint sum_a(input logic [NA*WA-1:0] c, input logic [NA*WA-1:0] r);
    longint s = 0;
    for (int k = 0; k < NA; k++) begin
      int x = int'(c[k*WA +: WA]);
      int y = int'(r[k*WA +: WA]);
      s += (x > y) ? x - y : y - x;
    end
    return s;
  endfunction

  function automatic longint sum_b(input logic [NB*WB-1:0] c, input logic [NB*WB-1:0] r);
    longint s = 0;
    for (int k = 0; k < NB; k++) begin
      int x = int'(c[k*WB +: WB]);
      int y = int'(r[k*WB +: WB]);
      s += (x > y) ? x - y : y - x;
    end
    return s;
  endfunction

  function automatic logic [NA*WA-1:0] fill_a(input int v);
    logic [NA*WA-1:0] x;
    for (int k = 0; k < NA; k++) x[k*WA +: WA] = WA'(v);
    return x;
  endfunction

  function automatic logic [NA*WA-1:0] rnd_a();
    logic [NA*WA-1:0] x;
    int sel = int'($urandom_range(0, 5));
    for (int k = 0; k < NA; k++)
      x[k*WA +: WA] = (sel == 0) ? '1 : (sel == 1) ? '0 : WA'($urandom);
    return x;
  endfunction

  function automatic logic [NB*WB-1:0] rnd_b();
    logic [NB*WB-1:0] x;
    int sel = int'($urandom_range(0, 5));
    for (int k = 0; k < NB; k++)
      x[k*WB +: WB] = (sel == 0) ? '1 : (sel == 1) ? '0 : WB'($urandom);
    return x;
  endfunction

  task automatic a_beat(input logic [NA*WA-1:0] c, input logic [NA*WA-1:0] r);
    bit ok = 1'b0;
    a_cur = c; a_ref = r; a_valid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (a_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) fail_now("a_accept");
    else begin
      a_part += sum_a(c, r);
      a_n++;
      if (a_n == BA) begin
        if (a_model) qa.push_back(a_part);
        a_part = 0; a_n = 0;
      end
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic b_beat(input logic [NB*WB-1:0] c, input logic [NB*WB-1:0] r);
    bit ok = 1'b0;
    b_cur = c; b_ref = r; b_valid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (b_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) fail_now("b_accept");
    else begin
      b_part += sum_b(c, r);
      b_n++;
      if (b_n == BB) begin
        qb.push_back(b_part);
        b_part = 0; b_n = 0;
      end
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic a_drain();
    for (int t = 0; t < 3000 && (qa.size() != 0 || a_sad_valid || a_busy); t++) @(negedge clk);
    if (qa.size() != 0) fail_now("a_drain");
    @(posedge clk); #1;
  endtask

  task automatic b_drain();
    for (int t = 0; t < 3000 && (qb.size() != 0 || b_sad_valid || b_busy); t++) @(negedge clk);
    if (qb.size() != 0) fail_now("b_drain");
    @(posedge clk); #1;
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = one 5-cycle hold on first result.
  int a_mode = 0;
  int bp_cnt = 0;
  bit bp_done = 1'b0;
  bit b_rand = 1'b0;

  always @(posedge clk) begin
    #1;
    case (a_mode)
      1: a_sad_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (!bp_done && a_sad_valid) begin
          if (bp_cnt < 5) begin a_sad_ready = 1'b0; bp_cnt++; end
          else begin a_sad_ready = 1'b1; bp_done = 1'b1; end
        end else a_sad_ready = 1'b1;
      end
      default: a_sad_ready = 1'b1;
    endcase
    b_sad_ready = b_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  bit             a_held = 1'b0, b_held = 1'b0;
  logic [AWA-1:0] a_hv;
  logic [AWB-1:0] b_hv;

  always @(negedge clk) begin
    if (!rst_n) a_held = 1'b0;
    else if (a_sad_valid) begin
      if (a_held) chk("a_sad_stable", longint'(a_sad), longint'(a_hv));
      if (!a_sad_ready) begin
        chk("a_ready_stall", longint'(a_ready), 0);
        a_held = 1'b1; a_hv = a_sad;
      end else begin
        a_held = 1'b0;
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected actual=%0d expected=no_result", a_sad);
        end else chk("a_sad", longint'(a_sad), qa.pop_front());
      end
    end else a_held = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) b_held = 1'b0;
    else if (b_sad_valid) begin
      if (b_held) chk("b_sad_stable", longint'(b_sad), longint'(b_hv));
      if (!b_sad_ready) begin
        chk("b_ready_stall", longint'(b_ready), 0);
        b_held = 1'b1; b_hv = b_sad;
      end else begin
        b_held = 1'b0;
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected actual=%0d expected=no_result", b_sad);
        end else chk("b_sad", longint'(b_sad), qb.pop_front());
      end
    end else b_held = 1'b0;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NA*WA-1:0] same;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sad_valid", longint'(a_sad_valid), 0);
    chk("rst_sad", longint'(a_sad), 0);
    chk("rst_busy", longint'(a_busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", longint'(a_ready), 1);
    @(posedge clk); #1;

    // Full scale, both polarities, with latency check on the first.
    qa.push_back(16320);
    for (int i = 0; i < 8; i++) a_beat(fill_a(255), fill_a(0));
    @(negedge clk); chk("lat_e1", longint'(a_sad_valid), 0);
    @(negedge clk); chk("lat_e2", longint'(a_sad_valid), 0);
    @(negedge clk); chk("lat_e3", longint'(a_sad_valid), 1);
    @(posedge clk); #1;
    qa.push_back(16320);
    for (int i = 0; i < 8; i++) a_beat(fill_a(0), fill_a(255));
    a_drain();

    // Identical pixels, then back-to-back constant-diff block.
    qa.push_back(0);
    for (int i = 0; i < 8; i++) begin
      same = rnd_a();
      a_beat(same, same);
    end
    qa.push_back(640);
    for (int i = 0; i < 8; i++) a_beat(fill_a(10), fill_a(20));
    a_drain();

    // Backpressure over three streamed blocks.
    a_mode = 2; bp_cnt = 0; bp_done = 1'b0;
    repeat (3) qa.push_back(64);
    for (int i = 0; i < 24; i++) a_beat(fill_a(1), fill_a(0));
    a_drain();
    chk("bp_hold_done", longint'(bp_done), 1);
    a_mode = 0;

    // Clear mid-block, dropping a beat presented with the clear.
    for (int i = 0; i < 3; i++) a_beat(fill_a(100), fill_a(0));
    a_clear = 1'b1; a_valid = 1'b1; a_cur = fill_a(100); a_ref = fill_a(0);
    @(negedge clk);
    chk("clr_ready", longint'(a_ready), 0);
    chk("clr_busy_before", longint'(a_busy), 1);
    @(posedge clk); #1;
    a_clear = 1'b0; a_valid = 1'b0;
    a_part = 0; a_n = 0;
    @(negedge clk);
    chk("clr_busy_after", longint'(a_busy), 0);
    @(posedge clk); #1;
    qa.push_back(64);
    for (int i = 0; i < 8; i++) a_beat(fill_a(1), fill_a(0));
    a_drain();

    // Asynchronous reset mid-block.
    for (int i = 0; i < 5; i++) a_beat(fill_a(7), fill_a(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sad_valid", longint'(a_sad_valid), 0);
    chk("arst_sad", longint'(a_sad), 0);
    chk("arst_busy", longint'(a_busy), 0);
    a_part = 0; a_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    qa.push_back(128);
    for (int i = 0; i < 8; i++) a_beat(fill_a(2), fill_a(0));
    a_drain();

    // Constrained-random traffic on both configurations.
    a_model = 1'b1; a_mode = 1; b_rand = 1'b1;
    fork
      begin
        for (int blk = 0; blk < 1000; blk++)
          for (int i = 0; i < BA; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
            a_beat(rnd_a(), rnd_a());
          end
      end
      begin
        for (int blk = 0; blk < 1000; blk++)
          for (int i = 0; i < BB; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
            b_beat(rnd_b(), rnd_b());
          end
      end
    join
    a_drain();
    b_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
